// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-wide memory bus arbiter: FSM encoding,
// lsb_op field layout and load opcodes.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } arb_state_e;

  localparam int OP_SIZE_LSB     = 0;
  localparam int OP_SIZE_MSB     = 1;
  localparam int OP_UNSIGNED_BIT = 2;

  localparam logic [1:0] IO_BASE_SEL_DEFAULT = 2'b11;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_LHU = 3'd5;

  // Byte count of an access; the unused size code 3 moves a full word.
  function automatic logic [2:0] op_bytes(input logic [2:0] op);
    case (op[OP_SIZE_MSB:OP_SIZE_LSB])
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_load_ext.sv
// Combinational load formatter: picks and extends bytes of a little-endian
// 4-byte buffer according to lsb_op. Also usable by the LSB forwarding path.
module mem_load_ext
  import mem_arbiter_pkg::*;
(
  input  logic [31:0] ld_word,
  input  logic [2:0]  ld_op,
  output logic [31:0] ld_rdata
);

  always_comb begin
    ld_rdata = '0;
    case (ld_op)
      OP_LB:   ld_rdata = {{24{ld_word[7]}}, ld_word[7:0]};
      OP_LBU:  ld_rdata = {24'd0, ld_word[7:0]};
      OP_LH:   ld_rdata = {{16{ld_word[15]}}, ld_word[15:0]};
      OP_LHU:  ld_rdata = {16'd0, ld_word[15:0]};
      OP_LW:   ld_rdata = ld_word;
      default: ld_rdata = '0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single byte-wide RAM/IO bus between the instruction fetcher
// and the load/store buffer, splitting each request into byte beats.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit         FAIR        = 1'b1,
  parameter logic [1:0] IO_BASE_SEL = IO_BASE_SEL_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rob_clear,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        lsb_req,
  input  logic        lsb_we,
  input  logic [2:0]  lsb_op,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata,
  output logic        busy
);

  arb_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  n_q, n_d;
  logic        owner_lsb_q, owner_lsb_d;
  logic        last_lsb_q, last_lsb_d;
  logic        we_q, we_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] lsb_rdata_q, lsb_rdata_d;

  logic        accept;
  logic        grant_lsb;
  logic        issue_rd;
  logic        io_stall;
  logic [2:0]  rcv_idx;
  logic [31:0] ext_rdata;

  // Round-robin: the side not granted last time wins a contest.
  assign grant_lsb = lsb_req && (!if_req || !FAIR || !last_lsb_q);
  assign accept    = (state_q == ST_IDLE) && rdy && !rob_clear && (if_req || lsb_req);
  assign issue_rd  = (state_q == ST_RD) && (cnt_q != n_q);
  assign io_stall  = (addr_q[17:16] == IO_BASE_SEL) && io_buffer_full;
  assign rcv_idx   = cnt_q - 3'd1;

  assign mem_a     = (issue_rd || state_q == ST_WR) ? addr_q + {29'd0, cnt_q} : '0;
  assign mem_dout  = (state_q == ST_WR) ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : '0;
  assign mem_wr    = rdy && (state_q == ST_WR) && !io_stall;
  assign busy      = (state_q != ST_IDLE);
  assign if_done   = (state_q == ST_DONE) && rdy && !owner_lsb_q && !rob_clear;
  assign lsb_done  = (state_q == ST_DONE) && rdy && owner_lsb_q && (we_q || !rob_clear);
  assign if_data   = if_data_q;
  assign lsb_rdata = lsb_rdata_q;

  // RAM data lags the address by one cycle, so byte cnt-1 arrives now.
  always_comb begin
    buf_d = buf_q;
    if ((state_q == ST_RD) && rdy && !rob_clear && (cnt_q != 3'd0)) begin
      buf_d[{rcv_idx[1:0], 3'b000} +: 8] = mem_din;
    end
  end

  mem_load_ext u_load_ext (
    .ld_word  (buf_d),
    .ld_op    (op_q),
    .ld_rdata (ext_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    owner_lsb_d = owner_lsb_q;
    last_lsb_d  = last_lsb_q;
    we_d        = we_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_data_d   = if_data_q;
    lsb_rdata_d = lsb_rdata_q;
    if (rdy) begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            owner_lsb_d = grant_lsb;
            last_lsb_d  = grant_lsb;
            we_d        = grant_lsb && lsb_we;
            op_d        = grant_lsb ? lsb_op : OP_LW;
            n_d         = grant_lsb ? op_bytes(lsb_op) : 3'd4;
            addr_d      = grant_lsb ? lsb_addr : if_addr;
            wdata_d     = lsb_wdata;
            cnt_d       = '0;
            state_d     = (grant_lsb && lsb_we) ? ST_WR : ST_RD;
          end
        end
        ST_RD: begin
          if (rob_clear) begin
            state_d = ST_IDLE;
          end else if (cnt_q == n_q) begin
            state_d = ST_DONE;
            if (owner_lsb_q) lsb_rdata_d = ext_rdata;
            else             if_data_d   = buf_d;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        // Stores are already committed, so a flush does not stop them.
        ST_WR: begin
          if (!io_stall) begin
            if (cnt_q == n_q - 3'd1) state_d = ST_DONE;
            else                     cnt_d   = cnt_q + 3'd1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      n_q         <= '0;
      owner_lsb_q <= 1'b0;
      last_lsb_q  <= 1'b0;
      we_q        <= 1'b0;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      if_data_q   <= '0;
      lsb_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      owner_lsb_q <= owner_lsb_d;
      last_lsb_q  <= last_lsb_d;
      we_q        <= we_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      if_data_q   <= if_data_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end

endmodule
